ace_request_arbiter: RTL

ACE_REQUEST_ARBITER -- requirements
Module: ace_request_arbiter

---
 rtl/ace_request_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ace_request_arbiter.sv
// Round-robin arbiter sharing one ACE port among NUM_REQ cache controllers; ACE_ARB_TIMEOUT_EN adds a BUSY watchdog.
// Latency: grant and ace_*_req one cycle after a request is seen in IDLE; done one cycle after ace_ready.
// Backpressure: requests are level-held until done; the owner holds the port until ace_ready (or watchdog).
module ace_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_read,
  input  logic [NUM_REQ-1:0] req_write,
  input  logic [NUM_REQ-1:0] req_invalid,
  input  logic               ace_ready,
  output logic               ace_read_req,
  output logic               ace_write_req,
  output logic               ace_invalid_req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ace_request_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q;
  logic [IDX_W-1:0]   winner_q;
  logic [2:0]         kind_q;      // {write, invalid, read}, one-hot
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [2:0]         pick_kind;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] winner_oh;
  logic               in_busy;
  logic               tmo_hit;
  logic               done_en;

  assign pending   = req_read | req_write | req_invalid;
  assign in_busy   = (state_q == BUSY);
  assign winner_oh = NUM_REQ'(1) << winner_q;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!pick_vld && pending[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    pick_kind = 3'b001;
    if (req_write[pick_idx]) begin
      pick_kind = 3'b100;
    end else if (req_invalid[pick_idx]) begin
      pick_kind = 3'b010;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = BUSY;
      BUSY:    if (ace_ready || tmo_hit) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      winner_q     <= '0;
      kind_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_vld) begin
        winner_q <= pick_idx;
        kind_q   <= pick_kind;
      end
      if (state_q == RELEASE) begin
        last_grant_q <= winner_q;
      end
    end
  end

`ifdef ACE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_flag_q;
  logic             timeout_err_q;

  // Fires on the TIMEOUT_CYCLES-th BUSY cycle that ends without ace_ready.
  assign tmo_hit = in_busy && !ace_ready && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      tmo_flag_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (in_busy && !ace_ready && !tmo_hit) ? tmo_cnt_q + CNT_W'(1) : '0;
      if (in_busy) begin
        tmo_flag_q <= tmo_hit;
      end
      timeout_err_q <= timeout_err_q | tmo_hit;
    end
  end

  assign done_en     = !tmo_flag_q;
  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign done_en     = 1'b1;
  assign timeout_err = 1'b0;
`endif

  assign grant           = in_busy ? winner_oh : '0;
  assign ace_write_req   = in_busy & kind_q[2];
  assign ace_invalid_req = in_busy & kind_q[1];
  assign ace_read_req    = in_busy & kind_q[0];
  assign done            = (state_q == RELEASE && done_en) ? winner_oh : '0;
  assign busy            = (state_q != IDLE);

endmodule
